instruction_fetch: RTL and testbench

//  Fetch stage driving instructionmemory: presents pc_addr, captures the combinational

---
 rtl/instruction_fetch_pkg.sv | 25 ++
 rtl/instruction_fetch_if.sv | 28 ++
 rtl/instruction_fetch_out_slice.sv | 42 ++++
 rtl/instruction_fetch.sv | 106 ++++++++++
 tb/tb_instruction_fetch.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: widths, halt encoding, FSM state
// encodings, the {pc, instr} payload carried to decode, and the pc increment.
package instruction_fetch_pkg;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 16;

  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

  // Sequential pc step; wraps naturally at 2^PC_W.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch -> decode valid/ready bus.
//   out_valid : fetched instruction held on out_pc/out_instr
//   out_ready : decode accepts when out_valid && out_ready
//   out_pc    : address of out_instr
//   out_instr : fetched instruction word
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic                out_valid;
  logic                out_ready;
  logic [PC_W-1:0]     out_pc;
  logic [INSTR_W-1:0]  out_instr;

  modport master (
    output out_valid,
    output out_pc,
    output out_instr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output out_ready
  );

endinterface

// File: rtl/instruction_fetch_out_slice.sv
// Valid/ready register slice holding the {pc, instr} handed to decode.
//   clk, reset_n : clock, async active-low reset
//   load         : capture in_pkt and raise valid
//   flush        : drop the held entry (wins over load)
//   in_pkt       : payload to capture
//   dec          : decode-side bus (master)
module instruction_fetch_out_slice
  import instruction_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                flush,
  input  fetch_pkt_t          in_pkt,
  instruction_fetch_if.master dec
);

  fetch_pkt_t pkt_q;
  logic       valid_q;

  // Payload only changes on load, so a stalled entry stays stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
        pkt_q   <= in_pkt;
      end else if (valid_q && dec.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign dec.out_valid = valid_q;
  assign dec.out_pc    = pkt_q.pc;
  assign dec.out_instr = pkt_q.instr;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the pc, drives instruction memory, forwards {pc, instr}
// to decode through a register slice, stops on HALT_WORD, restarts on branch,
// and counts instructions accepted by decode.
//   clk, reset_n  : clock, async active-low reset
//   start         : IDLE -> RUN pulse
//   pc_addr       : instruction memory address (= pc register)
//   imem_instr    : instruction memory read data (combinational from pc_addr)
//   branch_valid  : redirect request, branch_target : redirect address
//   dec           : decode bus (out_valid/out_ready/out_pc/out_instr)
//   halted        : high in HALT
//   fetch_count   : saturating count of accepted instructions
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic [PC_W-1:0]     pc_addr,
  input  logic [INSTR_W-1:0]  imem_instr,
  input  logic                branch_valid,
  input  logic [PC_W-1:0]     branch_target,
  instruction_fetch_if.master dec,
  output logic                halted,
  output logic [CNT_W-1:0]    fetch_count
);

  logic [1:0]      state_q, state_n;
  logic [PC_W-1:0] pc_q, pc_n;
  logic            load, flush;
  logic            slot_free;
  logic            accept;
  fetch_pkt_t      cap_pkt;

  assign accept  = dec.out_valid && dec.out_ready;
  assign cap_pkt = '{pc: pc_q, instr: imem_instr};
  assign pc_addr = pc_q;

  // State, pc, halt flag and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      halted  <= (state_n == ST_HALT);
      if (accept && (fetch_count != {CNT_W{1'b1}})) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

  // Next state / pc; a redirect takes priority over capture and stall.
  always_comb begin
    state_n   = state_q;
    pc_n      = pc_q;
    load      = 1'b0;
    flush     = 1'b0;
    slot_free = !dec.out_valid || dec.out_ready;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (branch_valid) begin
          pc_n  = branch_target;
          flush = 1'b1;
        end else if (slot_free) begin
          load = 1'b1;
          // Halt word is delivered but the pc stays on it.
          if (imem_instr == HALT_WORD) begin
            state_n = ST_HALT;
          end else begin
            pc_n = pc_next(pc_q);
          end
        end
      end
      ST_HALT: begin
        if (branch_valid) begin
          pc_n    = branch_target;
          flush   = 1'b1;
          state_n = ST_RUN;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  instruction_fetch_out_slice u_out_slice (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .flush   (flush),
    .in_pkt  (cap_pkt),
    .dec     (dec)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic                clk;
  logic                reset_n;
  logic                start;
  logic [PC_W-1:0]     pc_addr;
  logic [INSTR_W-1:0]  imem_instr;
  logic                branch_valid;
  logic [PC_W-1:0]     branch_target;
  logic                halted;
  logic [CNT_W-1:0]    fetch_count;

  instruction_fetch_if dec_if ();

  logic [INSTR_W-1:0] imem [1024];
  assign imem_instr = imem[pc_addr];

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .pc_addr       (pc_addr),
    .imem_instr    (imem_instr),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .dec           (dec_if),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_start();
    reset_n = 1'b0;
    start   = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  initial begin
    // Program image: imem[i] = (i+1)*10, imem[6] = halt.
    for (int i = 0; i < 1024; i++) imem[i] = 32'((i + 1) * 10);
    imem[6] = HALT_WORD;

    reset_n          = 1'b0;
    start            = 1'b0;
    branch_valid     = 1'b0;
    branch_target    = '0;
    dec_if.out_ready = 1'b1;
    #1;
    check("rst_valid", 64'(dec_if.out_valid), 64'd0);
    check("rst_pc_out", 64'(dec_if.out_pc), 64'd0);
    check("rst_instr", 64'(dec_if.out_instr), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_count", 64'(fetch_count), 64'd0);
    check("rst_pc_addr", 64'(pc_addr), 64'd0);

    // IDLE: branch ignored, nothing fetched.
    step();
    reset_n = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 10'd77;
    step();
    branch_valid  = 1'b0;
    step();
    check("idle_pc", 64'(pc_addr), 64'd0);
    check("idle_valid", 64'(dec_if.out_valid), 64'd0);

    // 1: free run from 0.
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_first_valid", 64'(dec_if.out_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_valid", 64'(dec_if.out_valid), 64'd1);
      check("t1_pc", 64'(dec_if.out_pc), 64'(k));
      check("t1_instr", 64'(dec_if.out_instr), 64'((k + 1) * 10));
      check("t1_count", 64'(fetch_count), 64'(k));
    end
    step();
    check("t1_count4", 64'(fetch_count), 64'd4);
    check("t1_pc4", 64'(dec_if.out_pc), 64'd4);

    // 2: stall while out_pc = 2.
    reset_and_start();
    step();
    step();
    step();
    check("t2_pc2", 64'(dec_if.out_pc), 64'd2);
    dec_if.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_stall_valid", 64'(dec_if.out_valid), 64'd1);
      check("t2_stall_pc", 64'(dec_if.out_pc), 64'd2);
      check("t2_stall_instr", 64'(dec_if.out_instr), 64'd30);
      check("t2_stall_addr", 64'(pc_addr), 64'd3);
      check("t2_stall_count", 64'(fetch_count), 64'd2);
    end
    dec_if.out_ready = 1'b1;
    step();
    check("t2_resume_pc", 64'(dec_if.out_pc), 64'd3);
    check("t2_resume_count", 64'(fetch_count), 64'd3);

    // 3: redirect during a stall at out_pc = 5.
    step();
    step();
    check("t3_pc5", 64'(dec_if.out_pc), 64'd5);
    check("t3_count5", 64'(fetch_count), 64'd5);
    dec_if.out_ready = 1'b0;
    step();
    branch_valid  = 1'b1;
    branch_target = 10'd100;
    step();
    branch_valid     = 1'b0;
    dec_if.out_ready = 1'b1;
    check("t3_flush_valid", 64'(dec_if.out_valid), 64'd0);
    check("t3_flush_addr", 64'(pc_addr), 64'd100);
    check("t3_flush_count", 64'(fetch_count), 64'd5);
    step();
    check("t3_tgt_valid", 64'(dec_if.out_valid), 64'd1);
    check("t3_tgt_pc", 64'(dec_if.out_pc), 64'd100);
    check("t3_tgt_instr", 64'(dec_if.out_instr), 64'd1010);
    check("t3_tgt_count", 64'(fetch_count), 64'd5);

    // 4: halt at 6, then restart at 0.
    branch_valid  = 1'b1;
    branch_target = 10'd5;
    step();
    branch_valid  = 1'b0;
    check("t4_flush_count", 64'(fetch_count), 64'd6);
    step();
    check("t4_pc5", 64'(dec_if.out_pc), 64'd5);
    step();
    check("t4_halt_instr", 64'(dec_if.out_instr), 64'hFFFF_FFFF);
    check("t4_halt_pc", 64'(dec_if.out_pc), 64'd6);
    check("t4_halted", 64'(halted), 64'd1);
    check("t4_halt_addr", 64'(pc_addr), 64'd6);
    check("t4_halt_count", 64'(fetch_count), 64'd7);
    dec_if.out_ready = 1'b0;
    step();
    check("t4_hold_valid", 64'(dec_if.out_valid), 64'd1);
    check("t4_hold_count", 64'(fetch_count), 64'd7);
    dec_if.out_ready = 1'b1;
    step();
    check("t4_drop_valid", 64'(dec_if.out_valid), 64'd0);
    check("t4_drop_count", 64'(fetch_count), 64'd8);
    check("t4_drop_addr", 64'(pc_addr), 64'd6);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4_start_ign", 64'(halted), 64'd1);
    check("t4_start_valid", 64'(dec_if.out_valid), 64'd0);
    check("t4_start_addr", 64'(pc_addr), 64'd6);
    branch_valid  = 1'b1;
    branch_target = 10'd0;
    step();
    branch_valid  = 1'b0;
    check("t4_restart_halted", 64'(halted), 64'd0);
    check("t4_restart_addr", 64'(pc_addr), 64'd0);
    check("t4_restart_valid", 64'(dec_if.out_valid), 64'd0);
    step();
    check("t4_restart_pc", 64'(dec_if.out_pc), 64'd0);
    check("t4_restart_instr", 64'(dec_if.out_instr), 64'd10);
    check("t4_restart_count", 64'(fetch_count), 64'd8);

    // 5: pc wrap at 1023.
    branch_valid  = 1'b1;
    branch_target = 10'd1023;
    step();
    branch_valid  = 1'b0;
    check("t5_flush_count", 64'(fetch_count), 64'd9);
    step();
    check("t5_pc_top", 64'(dec_if.out_pc), 64'd1023);
    check("t5_instr_top", 64'(dec_if.out_instr), 64'd10240);
    check("t5_wrap_addr", 64'(pc_addr), 64'd0);
    step();
    check("t5_wrap_pc", 64'(dec_if.out_pc), 64'd0);
    check("t5_wrap_instr", 64'(dec_if.out_instr), 64'd10);
    check("t5_wrap_count", 64'(fetch_count), 64'd10);

    // 6: asynchronous reset mid-run, between clock edges.
    check("t6_pre_valid", 64'(dec_if.out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(dec_if.out_valid), 64'd0);
    check("t6_async_count", 64'(fetch_count), 64'd0);
    check("t6_async_addr", 64'(pc_addr), 64'd0);
    check("t6_async_pc", 64'(dec_if.out_pc), 64'd0);
    #2;
    reset_n = 1'b1;
    step();
    step();
    step();
    check("t6_idle_valid", 64'(dec_if.out_valid), 64'd0);
    check("t6_idle_addr", 64'(pc_addr), 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t6_resume_valid", 64'(dec_if.out_valid), 64'd1);
    check("t6_resume_pc", 64'(dec_if.out_pc), 64'd0);
    check("t6_resume_instr", 64'(dec_if.out_instr), 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
